// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - iterative round controller and state register for a 64-bit four-row cipher
//
// Purpose: loads a plaintext block and fetches one 32-bit round key per round.
//   Each round runs KEY (key addition), then SUB (substitution result capture),
//   then LIN (row rotation). After NR rounds it returns the ciphertext.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready, pt       plaintext handshake, rows packed row0..row3 from bit 0
//   rkey_req/rkey_idx           round key request and round number
//   rkey_valid/rkey             round key return
//   sl_row0..3, sl_rkey         rows and latched key to the substitution layer
//   sl_res0..3                  combinational substitution-layer result
//   out_valid/out_ready, ct     ciphertext handshake, same packing as pt

module round_ctrl #(
  parameter int NR = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] pt,
  output logic        rkey_req,
  output logic [0:7]  rkey_idx,
  input  logic        rkey_valid,
  input  logic [0:31] rkey,
  output logic [0:15] sl_row0,
  output logic [0:15] sl_row1,
  output logic [0:15] sl_row2,
  output logic [0:15] sl_row3,
  output logic [0:31] sl_rkey,
  input  logic [0:15] sl_res0,
  input  logic [0:15] sl_res1,
  input  logic [0:15] sl_res2,
  input  logic [0:15] sl_res3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] ct
);

  typedef enum logic [2:0] {IDLE, KEY, SUB, LIN, DONE} state_t;

  localparam logic [0:7] LAST_ROUND = 8'(NR - 1);

  state_t      state_q;
  logic [0:15] row0_q, row1_q, row2_q, row3_q;
  logic [0:15] row0_d, row1_d, row2_d, row3_d;
  logic [0:31] key_q;
  logic [0:7]  round_q;
  logic [0:63] ct_q;
  logic        in_ready_q, rkey_req_q, out_valid_q;

  assign in_ready  = in_ready_q;
  assign rkey_req  = rkey_req_q;
  assign rkey_idx  = round_q;
  assign out_valid = out_valid_q;
  assign ct        = ct_q;
  assign sl_row0   = row0_q;
  assign sl_row1   = row1_q;
  assign sl_row2   = row2_q;
  assign sl_row3   = row3_q;
  assign sl_rkey   = key_q;

  // Row datapath next state; rotations move bit n to index 0 (the MSB).
  always_comb begin
    row0_d = row0_q;
    row1_d = row1_q;
    row2_d = row2_q;
    row3_d = row3_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          row0_d = pt[0:15];
          row1_d = pt[16:31];
          row2_d = pt[32:47];
          row3_d = pt[48:63];
        end
      end
      KEY: begin
        if (rkey_valid) begin
          row0_d = row0_q ^ rkey[0:15];
          row1_d = row1_q ^ rkey[16:31];
        end
      end
      SUB: begin
        row0_d = sl_res0;
        row1_d = sl_res1;
        row2_d = sl_res2;
        row3_d = sl_res3;
      end
      LIN: begin
        row1_d = {row1_q[1:15],  row1_q[0]};
        row2_d = {row2_q[12:15], row2_q[0:11]};
        row3_d = {row3_q[13:15], row3_q[0:12]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row0_q      <= '0;
      row1_q      <= '0;
      row2_q      <= '0;
      row3_q      <= '0;
      key_q       <= '0;
      round_q     <= '0;
      ct_q        <= '0;
      in_ready_q  <= 1'b1;
      rkey_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      row0_q <= row0_d;
      row1_q <= row1_d;
      row2_q <= row2_d;
      row3_q <= row3_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            round_q    <= '0;
            in_ready_q <= 1'b0;
            rkey_req_q <= 1'b1;
            state_q    <= KEY;
          end
        end
        KEY: begin
          if (rkey_valid) begin
            key_q      <= rkey;
            rkey_req_q <= 1'b0;
            state_q    <= SUB;
          end
        end
        SUB: state_q <= LIN;
        LIN: begin
          if (round_q == LAST_ROUND) begin
            // ct is taken from the post-rotation rows and then held past the handshake.
            ct_q        <= {row0_d, row1_d, row2_d, row3_d};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            round_q    <= round_q + 8'd1;
            rkey_req_q <= 1'b1;
            state_q    <= KEY;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
